button_event_ctrl: RTL and testbench
====================================

# button_event_ctrl

Debounce and event controller for a bank of raw push-button inputs. One shared tick prescaler sequences per-channel stability counters; the block produces clean levels plus press, release and long-press events. A round-robin arbiter shares a single valid/ready event port between all channels. It sits between the board buttons and the UI/command logic, so downstream logic never sees bounce.

## Interface
- N_BTN, 4, number of button channels (2..16)
- TICK_DIV, 100000, clk_in cycles per debounce tick (1 ms at 100 MHz); ≥2
- STABLE_TICKS, 10, consecutive ticks an input must differ from level_out before level_out changes; ≥1
- LONG_TICKS, 1000, ticks level_out must stay 1 before a long-press event; > STABLE_TICKS

- clk_in  input  1  the single clock; all logic is on its rising edge
- rst_in  input  1  asynchronous, active-low reset
- btn_in  input  N_BTN  raw, asynchronous, bouncy button inputs; 1 = pressed
- level_out  output  N_BTN  debounced levels, registered
- evt_valid_out  output  1  event available
- evt_ready_in  input  1  consumer accepts event when high with evt_valid_out
- evt_chan_out  output  $clog2(N_BTN)  channel of the current event
- evt_type_out  output  2  01 press, 10 release, 11 long-press (00 never driven while valid)
- evt_drop_out  output  1  one-cycle pulse: an event was lost because its pending slot was full

## Operation
- Reset (rst_in=0, async): all outputs 0, synchronizers 0, tick counter 0, stability/hold counters 0, pending flags 0, round-robin pointer 0.
- Synchronizer: each btn_in bit passes through 2 flops → sync[i].
- Tick: counter counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle the counter equals TICK_DIV-1.
- Stability, per channel:
  - sync==level: stab_cnt←0.
  - Otherwise, on tick: if stab_cnt==STABLE_TICKS-1, then level←sync, stab_cnt←0, and a press (0→1) or release (1→0) event is raised. Else stab_cnt+1.
  - A glitch lasting less than STABLE_TICKS ticks never changes level_out.
- Long press, per channel:
  - hold_cnt←0 while level=0.
  - While level=1, it increments on tick and saturates at LONG_TICKS.
  - The long event is raised once per press, on the tick where hold_cnt goes LONG_TICKS-1→LONG_TICKS.
- Pending flags: one flag each for press, release and long per channel.
  - A raised event sets its flag.
  - If the flag is already set and is not cleared in the same cycle, the event is discarded and evt_drop_out pulses.
  - Set and clear in the same cycle: set wins, no drop.
- Arbiter and output register:
  - The register loads when evt_valid_out=0, or when evt_valid_out&&evt_ready_in.
  - Search order starts at the channel after the last granted channel, wraps modulo N_BTN, and takes the first channel with any pending flag.
  - Within a channel, priority is press > long > release.
  - Loading clears the chosen flag and sets the pointer to that channel.
  - No pending flag: evt_valid_out←0.
- Handshake:
  - While evt_valid_out=1 and evt_ready_in=0, chan and type stay stable.
  - Back-to-back acceptance gives one event per cycle.

## Timing
- btn_in→sync: 2 cycles.
- Level change: occurs (STABLE_TICKS-1)·TICK_DIV+1 to STABLE_TICKS·TICK_DIV cycles after sync settles, depending on tick phase.
- level_out and the event flag update on the same edge. evt_valid_out rises one edge later if the output register is free.
- Worst-case arbitration wait is N_BTN-1 accepted events: round-robin is starvation-free.
- evt_drop_out is high for exactly the cycle after the overflowing raise.
- Reset asserted mid-operation clears everything immediately, including any event being presented. Events still pending are lost silently, with no drop pulse.
- No combinational path from evt_ready_in to any output.

## Test plan
Bench parameters: N_BTN=4, TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=8.
- Clean press: btn_in[1] 0→1 held → level_out[1]=1 within 2+9..12 cycles; then evt_valid_out=1, chan=1, type=01. After release, type=10 appears.
- Bounce: btn_in[0] toggles every 5 cycles for 40 cycles, then settles at 1 → a single press event only, and level_out[0] never pulses before settling.
- Long press: hold btn_in[2] for 60 cycles with evt_ready_in=1 → events in order 01, 11 (once), then 10 after release. No second 11.
- Arbitration: evt_ready_in=0 while channels 0, 2 and 3 press simultaneously, then ready=1 → chan sequence 0, 2, 3. The output holds chan 0 stable during the stall.
- Overflow: with ready=0, press/release/press on channel 3 → evt_drop_out pulses once on the second press. Then ready=1 delivers 01, 10.
- Async reset: assert rst_in=0 mid-stall with evt_valid_out=1 → all outputs 0 immediately. After release, no stale events appear.

Source files
------------

// File: rtl/button_event_ctrl.sv
// Debounce and event controller for a bank of push buttons: synchronizes, debounces,
// detects press/release/long-press and serializes events through one valid/ready port.
module button_event_ctrl #(
  parameter int unsigned N_BTN        = 4,
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned STABLE_TICKS = 10,
  parameter int unsigned LONG_TICKS   = 1000
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [N_BTN-1:0]           btn_in,
  output logic [N_BTN-1:0]           level_out,
  output logic                       evt_valid_out,
  input  logic                       evt_ready_in,
  output logic [$clog2(N_BTN)-1:0]   evt_chan_out,
  output logic [1:0]                 evt_type_out,
  output logic                       evt_drop_out
);

  localparam int unsigned CW = $clog2(N_BTN);
  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned SW = $clog2(STABLE_TICKS + 1);
  localparam int unsigned HW = $clog2(LONG_TICKS + 1);

  localparam logic [1:0] TYPE_PRESS   = 2'b01;
  localparam logic [1:0] TYPE_RELEASE = 2'b10;
  localparam logic [1:0] TYPE_LONG    = 2'b11;

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [TW-1:0]    tick_cnt_q;
  logic             tick_c;

  logic [SW-1:0]    stab_q [N_BTN];
  logic [SW-1:0]    stab_d [N_BTN];
  logic [HW-1:0]    hold_q [N_BTN];
  logic [HW-1:0]    hold_d [N_BTN];
  logic [N_BTN-1:0] level_d;

  logic [N_BTN-1:0] rise_press_c, rise_rel_c, rise_long_c;
  logic [N_BTN-1:0] press_q, rel_q, long_q;
  logic [N_BTN-1:0] press_d, rel_d, long_d;
  logic [N_BTN-1:0] clr_press_c, clr_rel_c, clr_long_c;
  logic [N_BTN-1:0] pend_any_c;
  logic             drop_c;

  logic [CW-1:0]    ptr_q;
  logic             load_c;
  logic             found_c;
  logic [CW-1:0]    gnt_c;
  logic [1:0]       gtype_c;
  int               idx;

  assign tick_c = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign load_c = !evt_valid_out || evt_ready_in;

  // Per-channel stability and hold counters; raise events on qualifying ticks
  always_comb begin
    level_d      = level_out;
    rise_press_c = '0;
    rise_rel_c   = '0;
    rise_long_c  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      stab_d[i] = stab_q[i];
      hold_d[i] = hold_q[i];
      if (sync2_q[i] == level_out[i]) begin
        stab_d[i] = '0;
      end else if (tick_c) begin
        if (stab_q[i] == SW'(STABLE_TICKS - 1)) begin
          level_d[i]      = sync2_q[i];
          stab_d[i]       = '0;
          rise_press_c[i] = sync2_q[i];
          rise_rel_c[i]   = ~sync2_q[i];
        end else begin
          stab_d[i] = stab_q[i] + SW'(1);
        end
      end
      if (!level_out[i]) begin
        hold_d[i] = '0;
      end else if (tick_c && (hold_q[i] != HW'(LONG_TICKS))) begin
        hold_d[i]      = hold_q[i] + HW'(1);
        rise_long_c[i] = (hold_q[i] == HW'(LONG_TICKS - 1));
      end
    end
  end

  // Round-robin search starting after the last granted channel
  always_comb begin
    pend_any_c = press_q | rel_q | long_q;
    found_c    = 1'b0;
    gnt_c      = '0;
    idx        = 0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = (int'(ptr_q) + 1 + k) % int'(N_BTN);
      if (!found_c && pend_any_c[idx]) begin
        found_c = 1'b1;
        gnt_c   = CW'(idx);
      end
    end
    if (press_q[gnt_c])     gtype_c = TYPE_PRESS;
    else if (long_q[gnt_c]) gtype_c = TYPE_LONG;
    else                    gtype_c = TYPE_RELEASE;
  end

  // Pending-flag update; a new raise wins over a same-cycle clear
  always_comb begin
    clr_press_c = '0;
    clr_rel_c   = '0;
    clr_long_c  = '0;
    if (load_c && found_c) begin
      case (gtype_c)
        TYPE_PRESS: clr_press_c[gnt_c] = 1'b1;
        TYPE_LONG:  clr_long_c[gnt_c]  = 1'b1;
        default:    clr_rel_c[gnt_c]   = 1'b1;
      endcase
    end
    press_d = (press_q & ~clr_press_c) | rise_press_c;
    rel_d   = (rel_q   & ~clr_rel_c)   | rise_rel_c;
    long_d  = (long_q  & ~clr_long_c)  | rise_long_c;
    drop_c  = |((press_q & ~clr_press_c & rise_press_c) |
                (rel_q   & ~clr_rel_c   & rise_rel_c)   |
                (long_q  & ~clr_long_c  & rise_long_c));
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      tick_cnt_q    <= '0;
      level_out     <= '0;
      press_q       <= '0;
      rel_q         <= '0;
      long_q        <= '0;
      ptr_q         <= '0;
      evt_valid_out <= 1'b0;
      evt_chan_out  <= '0;
      evt_type_out  <= '0;
      evt_drop_out  <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        stab_q[i] <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      sync1_q      <= btn_in;
      sync2_q      <= sync1_q;
      tick_cnt_q   <= tick_c ? '0 : tick_cnt_q + TW'(1);
      level_out    <= level_d;
      press_q      <= press_d;
      rel_q        <= rel_d;
      long_q       <= long_d;
      evt_drop_out <= drop_c;
      for (int i = 0; i < N_BTN; i++) begin
        stab_q[i] <= stab_d[i];
        hold_q[i] <= hold_d[i];
      end
      if (load_c) begin
        evt_valid_out <= found_c;
        if (found_c) begin
          evt_chan_out <= gnt_c;
          evt_type_out <= gtype_c;
          ptr_q        <= gnt_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with small tick parameters.
module tb_button_event_ctrl;

  localparam int unsigned N_BTN        = 4;
  localparam int unsigned TICK_DIV     = 4;
  localparam int unsigned STABLE_TICKS = 3;
  localparam int unsigned LONG_TICKS   = 8;

  logic             clk_in;
  logic             rst_in;
  logic [3:0]       btn_in;
  logic [3:0]       level_out;
  logic             evt_valid_out;
  logic             evt_ready_in;
  logic [1:0]       evt_chan_out;
  logic [1:0]       evt_type_out;
  logic             evt_drop_out;

  int total = 0;
  int bad   = 0;
  int drop_cnt = 0;
  int n;
  int cnt;
  logic [3:0] evq[$];

  button_event_ctrl #(
    .N_BTN(N_BTN), .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS), .LONG_TICKS(LONG_TICKS)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .btn_in(btn_in), .level_out(level_out),
    .evt_valid_out(evt_valid_out), .evt_ready_in(evt_ready_in),
    .evt_chan_out(evt_chan_out), .evt_type_out(evt_type_out), .evt_drop_out(evt_drop_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) if (evt_drop_out === 1'b1) drop_cnt++;

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_level(input int ch, input logic val, output int edges);
    edges = 0;
    do begin
      step(1);
      edges++;
    end while (level_out[ch] !== val && edges < 40);
  endtask

  task automatic expect_evt(input string tag, input logic [1:0] ch, input logic [1:0] ty);
    chk({tag, "_valid"}, 32'(evt_valid_out), 32'(1'b1));
    chk({tag, "_chan"},  32'(evt_chan_out),  32'(ch));
    chk({tag, "_type"},  32'(evt_type_out),  32'(ty));
  endtask

  task automatic accept();
    evt_ready_in = 1'b1;
    step(1);
    evt_ready_in = 1'b0;
  endtask

  task automatic record(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      if (evt_valid_out === 1'b1) evq.push_back({evt_chan_out, evt_type_out});
      step(1);
    end
  endtask

  initial begin
    rst_in       = 1'b0;
    btn_in       = 4'b0000;
    evt_ready_in = 1'b0;
    step(3);
    chk("rst_level", 32'(level_out),     32'(4'b0000));
    chk("rst_valid", 32'(evt_valid_out), 32'(1'b0));
    chk("rst_chan",  32'(evt_chan_out),  32'(2'd0));
    chk("rst_type",  32'(evt_type_out),  32'(2'b00));
    chk("rst_drop",  32'(evt_drop_out),  32'(1'b0));
    rst_in = 1'b1;
    step(2);

    // clean press and release on channel 1
    btn_in = 4'b0010;
    wait_level(1, 1'b1, n);
    chk("press_latency_in_11_14", 32'(n >= 11 && n <= 14), 32'(1));
    chk("press_level", 32'(level_out), 32'(4'b0010));
    chk("press_valid_not_yet", 32'(evt_valid_out), 32'(1'b0));
    step(1);
    expect_evt("press1", 2'd1, 2'b01);
    accept();
    chk("idle_after_accept", 32'(evt_valid_out), 32'(1'b0));
    btn_in = 4'b0000;
    wait_level(1, 1'b0, n);
    chk("release_latency_in_11_14", 32'(n >= 11 && n <= 14), 32'(1));
    step(1);
    expect_evt("release1", 2'd1, 2'b10);
    accept();

    // bounce on channel 0 never reaches the output
    cnt = 0;
    for (int p = 0; p < 8; p++) begin
      btn_in[0] = (p % 2 == 0);
      for (int c = 0; c < 5; c++) begin
        step(1);
        if (level_out !== 4'b0000 || evt_valid_out !== 1'b0) cnt++;
      end
    end
    chk("bounce_no_glitch", 32'(cnt), 32'(0));
    btn_in[0] = 1'b1;
    wait_level(0, 1'b1, n);
    chk("bounce_settle_latency", 32'(n >= 11 && n <= 14), 32'(1));
    step(1);
    expect_evt("bounce_press", 2'd0, 2'b01);
    accept();
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      step(1);
      if (evt_valid_out !== 1'b0) cnt++;
    end
    chk("bounce_single_event", 32'(cnt), 32'(0));
    btn_in[0] = 1'b0;
    wait_level(0, 1'b0, n);
    step(1);
    expect_evt("bounce_release", 2'd0, 2'b10);
    accept();

    // long press on channel 2 with ready held high
    evt_ready_in = 1'b1;
    evq.delete();
    btn_in = 4'b0100;
    record(60);
    btn_in = 4'b0000;
    record(30);
    evt_ready_in = 1'b0;
    chk("long_count", 32'(evq.size()), 32'(3));
    chk("long_ev0", 32'(evq[0]), 32'(4'b1001));
    chk("long_ev1", 32'(evq[1]), 32'(4'b1011));
    chk("long_ev2", 32'(evq[2]), 32'(4'b1010));

    // overflow on channel 3 while a channel-1 release occupies the output
    btn_in = 4'b0010;
    wait_level(1, 1'b1, n);
    step(1);
    accept();
    btn_in = 4'b0000;
    wait_level(1, 1'b0, n);
    step(1);
    expect_evt("occupy", 2'd1, 2'b10);
    drop_cnt = 0;
    btn_in[3] = 1'b1;
    wait_level(3, 1'b1, n);
    chk("ovf_first_press_no_drop", 32'(evt_drop_out), 32'(1'b0));
    btn_in[3] = 1'b0;
    wait_level(3, 1'b0, n);
    chk("ovf_release_no_drop", 32'(evt_drop_out), 32'(1'b0));
    btn_in[3] = 1'b1;
    wait_level(3, 1'b1, n);
    chk("ovf_drop_pulse", 32'(evt_drop_out), 32'(1'b1));
    step(1);
    chk("ovf_drop_one_cycle", 32'(evt_drop_out), 32'(1'b0));
    chk("ovf_drop_count", 32'(drop_cnt), 32'(1));
    expect_evt("ovf_stall_stable", 2'd1, 2'b10);
    evt_ready_in = 1'b1;
    evq.delete();
    record(5);
    evt_ready_in = 1'b0;
    chk("ovf_count", 32'(evq.size()), 32'(3));
    chk("ovf_ev0", 32'(evq[0]), 32'(4'b0110));
    chk("ovf_ev1", 32'(evq[1]), 32'(4'b1101));
    chk("ovf_ev2", 32'(evq[2]), 32'(4'b1110));
    btn_in[3] = 1'b0;
    wait_level(3, 1'b0, n);
    step(1);
    expect_evt("ovf_final_release", 2'd3, 2'b10);
    accept();

    // simultaneous presses on 0, 2, 3 after last grant on channel 3
    btn_in = 4'b1101;
    n = 0;
    do begin
      step(1);
      n++;
    end while (level_out !== 4'b1101 && n < 40);
    chk("arb_levels", 32'(level_out), 32'(4'b1101));
    step(1);
    expect_evt("arb_first", 2'd0, 2'b01);
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      step(1);
      if (evt_valid_out !== 1'b1 || evt_chan_out !== 2'd0 || evt_type_out !== 2'b01) cnt++;
    end
    chk("arb_stall_stable", 32'(cnt), 32'(0));
    evt_ready_in = 1'b1;
    evq.delete();
    record(4);
    evt_ready_in = 1'b0;
    chk("arb_count", 32'(evq.size()), 32'(3));
    chk("arb_ev0", 32'(evq[0]), 32'(4'b0001));
    chk("arb_ev1", 32'(evq[1]), 32'(4'b1001));
    chk("arb_ev2", 32'(evq[2]), 32'(4'b1101));

    // long presses pile up; reset mid-stall wipes everything
    n = 0;
    while (evt_valid_out !== 1'b1 && n < 60) begin
      step(1);
      n++;
    end
    expect_evt("arb_long", 2'd0, 2'b11);
    #3;
    rst_in = 1'b0;
    #1;
    chk("mid_rst_level", 32'(level_out),     32'(4'b0000));
    chk("mid_rst_valid", 32'(evt_valid_out), 32'(1'b0));
    chk("mid_rst_chan",  32'(evt_chan_out),  32'(2'd0));
    chk("mid_rst_type",  32'(evt_type_out),  32'(2'b00));
    chk("mid_rst_drop",  32'(evt_drop_out),  32'(1'b0));
    btn_in = 4'b0000;
    step(2);
    rst_in = 1'b1;
    drop_cnt = 0;
    evt_ready_in = 1'b1;
    cnt = 0;
    for (int c = 0; c < 60; c++) begin
      step(1);
      if (evt_valid_out !== 1'b0) cnt++;
    end
    chk("post_rst_no_stale", 32'(cnt), 32'(0));
    chk("post_rst_no_drop", 32'(drop_cnt), 32'(0));
    chk("post_rst_level", 32'(level_out), 32'(4'b0000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
